spi_slave_param: RTL and testbench

//  Parametrised SPI slave; generalises the mode-3-only, 8-bit SPI slave to all four modes and any word width.

---
 rtl/spi_slave_param.sv | 194 +++++++++++++++++++
 tb/tb_spi_slave_param.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_param.sv
// SPI slave covering all four clock modes and any word width, clocked entirely by the system clock.
// sck/ss/mosi are oversampled through synchronisers; words stream back-to-back inside one ss frame.

module spi_slave_param #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sck,
    input  logic              i_ss,
    input  logic              i_mosi,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic              i_mol,
    input  logic [DATA_W-1:0] i_txr,
    output logic              o_miso,
    output logic              o_miso_oe,
    output logic [DATA_W-1:0] o_rxr,
    output logic              o_rdone,
    output logic              o_tdone,
    output logic              o_frame_err
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        StIdle,
        StActive
    } state_t;

    // Synchronisers and edge history
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_prev;
    logic                   r_ss_prev;

    // Frame state
    state_t            r_state;
    logic              r_cpol;
    logic              r_cpha;
    logic              r_mol;
    logic [DATA_W-1:0] r_tx_sh;
    logic [DATA_W-1:0] r_rx_sh;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_rxr;
    logic              r_miso_oe;
    logic              r_rdone;
    logic              r_tdone;
    logic              r_frame_err;

    // Next-state values
    state_t            w_state_nx;
    logic              w_cpol_nx;
    logic              w_cpha_nx;
    logic              w_mol_nx;
    logic [DATA_W-1:0] w_tx_sh_nx;
    logic [DATA_W-1:0] w_rx_sh_nx;
    logic [CNT_W-1:0]  w_bit_cnt_nx;
    logic [DATA_W-1:0] w_rxr_nx;
    logic              w_miso_oe_nx;
    logic              w_rdone_nx;
    logic              w_tdone_nx;
    logic              w_frame_err_nx;

    logic              w_sck_s;
    logic              w_ss_s;
    logic              w_mosi_s;
    logic              w_ss_fall;
    logic              w_sck_chg;
    logic              w_lead;
    logic              w_trail;
    logic              w_sample;
    logic              w_shift;
    logic [DATA_W-1:0] w_rx_word;

    assign w_sck_s   = r_sck_sync[SYNC_STAGES-1];
    assign w_ss_s    = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss_fall = r_ss_prev & ~w_ss_s;

    // A change away from the idle level is the leading edge; a change back is the trailing edge.
    assign w_sck_chg = w_sck_s ^ r_sck_prev;
    assign w_lead    = w_sck_chg & (r_sck_prev == r_cpol);
    assign w_trail   = w_sck_chg & (r_sck_prev != r_cpol);
    assign w_sample  = r_cpha ? w_trail : w_lead;
    assign w_shift   = r_cpha ? w_lead : w_trail;

    assign w_rx_word = r_mol ? {r_rx_sh[DATA_W-2:0], w_mosi_s}
                             : {w_mosi_s, r_rx_sh[DATA_W-1:1]};

    always_comb begin
        w_state_nx     = r_state;
        w_cpol_nx      = r_cpol;
        w_cpha_nx      = r_cpha;
        w_mol_nx       = r_mol;
        w_tx_sh_nx     = r_tx_sh;
        w_rx_sh_nx     = r_rx_sh;
        w_bit_cnt_nx   = r_bit_cnt;
        w_rxr_nx       = r_rxr;
        w_miso_oe_nx   = r_miso_oe;
        w_rdone_nx     = 1'b0;
        w_tdone_nx     = 1'b0;
        w_frame_err_nx = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_ss_fall) begin
                    w_state_nx   = StActive;
                    w_cpol_nx    = i_cpol;
                    w_cpha_nx    = i_cpha;
                    w_mol_nx     = i_mol;
                    w_tx_sh_nx   = i_txr;
                    w_bit_cnt_nx = '0;
                    w_miso_oe_nx = 1'b1;
                end
            end
            StActive: begin
                // ss release takes priority over any sck edge seen in the same cycle
                if (w_ss_s) begin
                    w_state_nx     = StIdle;
                    w_miso_oe_nx   = 1'b0;
                    w_frame_err_nx = (r_bit_cnt != '0);
                    w_bit_cnt_nx   = '0;
                end else if (w_sample) begin
                    w_rx_sh_nx = w_rx_word;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_rxr_nx     = w_rx_word;
                        w_rdone_nx   = 1'b1;
                        w_tdone_nx   = 1'b1;
                        w_tx_sh_nx   = i_txr;
                        w_bit_cnt_nx = '0;
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + 1'b1;
                    end
                end else if (w_shift && (r_bit_cnt != '0)) begin
                    // bit_cnt==0 means the current bit is already on miso (fresh load)
                    w_tx_sh_nx = r_mol ? (r_tx_sh << 1) : (r_tx_sh >> 1);
                end
            end
            default: w_state_nx = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sck_sync  <= '0;
            r_ss_sync   <= '0;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
            r_ss_prev   <= 1'b0;
            r_state     <= StIdle;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_mol       <= 1'b0;
            r_tx_sh     <= '0;
            r_rx_sh     <= '0;
            r_bit_cnt   <= '0;
            r_rxr       <= '0;
            r_miso_oe   <= 1'b0;
            r_rdone     <= 1'b0;
            r_tdone     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sck_prev  <= w_sck_s;
            r_ss_prev   <= w_ss_s;
            r_state     <= w_state_nx;
            r_cpol      <= w_cpol_nx;
            r_cpha      <= w_cpha_nx;
            r_mol       <= w_mol_nx;
            r_tx_sh     <= w_tx_sh_nx;
            r_rx_sh     <= w_rx_sh_nx;
            r_bit_cnt   <= w_bit_cnt_nx;
            r_rxr       <= w_rxr_nx;
            r_miso_oe   <= w_miso_oe_nx;
            r_rdone     <= w_rdone_nx;
            r_tdone     <= w_tdone_nx;
            r_frame_err <= w_frame_err_nx;
        end
    end

    assign o_miso      = r_miso_oe & (r_mol ? r_tx_sh[DATA_W-1] : r_tx_sh[0]);
    assign o_miso_oe   = r_miso_oe;
    assign o_rxr       = r_rxr;
    assign o_rdone     = r_rdone;
    assign o_tdone     = r_tdone;
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: 8-bit and 16-bit instances driven by a bit-level SPI master at clk/8,
// checked from fixed vectors, corner-case sequences and random frames against a word-level model.

module tb_spi_slave_param;

    localparam int HALF = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, m_sck, m_ss, m_mosi, p_cpol, p_cpha, p_mol, sel;
    logic [15:0] txr;
    logic        ss8, ss16;
    logic        miso8, oe8, rdone8, tdone8, fe8;
    logic [7:0]  rxr8;
    logic        miso16, oe16, rdone16, tdone16, fe16;
    logic [15:0] rxr16;

    assign ss8  = sel ? 1'b1 : m_ss;
    assign ss16 = sel ? m_ss : 1'b1;

    spi_slave_param #(.DATA_W(8), .SYNC_STAGES(2)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sck(m_sck), .i_ss(ss8), .i_mosi(m_mosi),
        .i_cpol(p_cpol), .i_cpha(p_cpha), .i_mol(p_mol), .i_txr(txr[7:0]),
        .o_miso(miso8), .o_miso_oe(oe8), .o_rxr(rxr8), .o_rdone(rdone8),
        .o_tdone(tdone8), .o_frame_err(fe8)
    );

    spi_slave_param #(.DATA_W(16), .SYNC_STAGES(2)) u_dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sck(m_sck), .i_ss(ss16), .i_mosi(m_mosi),
        .i_cpol(p_cpol), .i_cpha(p_cpha), .i_mol(p_mol), .i_txr(txr),
        .o_miso(miso16), .o_miso_oe(oe16), .o_rxr(rxr16), .o_rdone(rdone16),
        .o_tdone(tdone16), .o_frame_err(fe16)
    );

    int n_checks = 0;
    int n_errors = 0;
    int rd8 = 0, td8 = 0, fe8_cnt = 0, rd16 = 0, td16 = 0, fe16_cnt = 0;
    logic [15:0] rxq8[$];
    logic [15:0] rxq16[$];
    logic [15:0] last_rx[2];

    // Pulse monitor: every rdone logs the word presented on rxr
    always @(negedge clk) begin
        if (rdone8) begin rd8++; rxq8.push_back({8'h00, rxr8}); end
        if (tdone8) td8++;
        if (fe8) fe8_cnt++;
        if (rdone16) begin rd16++; rxq16.push_back(rxr16); end
        if (tdone16) td16++;
        if (fe16) fe16_cnt++;
    end

    function automatic logic cur_miso(); return sel ? miso16 : miso8; endfunction
    function automatic logic cur_oe(); return sel ? oe16 : oe8; endfunction
    function automatic logic [15:0] cur_rxr(); return sel ? rxr16 : {8'h00, rxr8}; endfunction
    function automatic int cur_td(); return sel ? td16 : td8; endfunction
    function automatic int cur_fe(); return sel ? fe16_cnt : fe8_cnt; endfunction
    function automatic int cur_rd(); return sel ? rd16 : rd8; endfunction
    function automatic int q_size(); return sel ? rxq16.size() : rxq8.size(); endfunction

    function automatic logic [15:0] q_pop();
        logic [15:0] v;
        v = 16'hxxxx;
        if (sel) begin
            if (rxq16.size() > 0) v = rxq16.pop_front();
        end else begin
            if (rxq8.size() > 0) v = rxq8.pop_front();
        end
        return v;
    endfunction

    task automatic q_clear();
        rxq8.delete();
        rxq16.delete();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_begin(input bit cpol, input bit cpha, input bit mol);
        p_cpol = cpol;
        p_cpha = cpha;
        p_mol  = mol;
        m_sck  = cpol;
        tick(2 * HALF);
        m_ss = 1'b0;
        tick(HALF);
    endtask

    task automatic frame_end();
        tick(HALF);
        m_ss = 1'b1;
        tick(3 * HALF);
    endtask

    // Master sends the first n bits of a w-bit word and captures miso at each sample edge
    task automatic spi_bits(input int w, input int n, input bit cpha, input bit mol,
                            input logic [15:0] data, output logic [15:0] cap);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            int idx;
            idx = mol ? (w - 1 - i) : i;
            m_mosi = data[idx];
            if (!cpha) begin
                tick(HALF);
                cap[idx] = cur_miso();
                m_sck = ~m_sck;
                tick(HALF);
                m_sck = ~m_sck;
            end else begin
                m_sck = ~m_sck;
                tick(HALF);
                cap[idx] = cur_miso();
                m_sck = ~m_sck;
                tick(HALF);
            end
        end
    endtask

    typedef struct {
        bit          cpol;
        bit          cpha;
        bit          mol;
        bit          wide;
        logic [15:0] mosi;
        logic [15:0] txr;
        logic [15:0] exp_rx;
        logic [15:0] exp_cap;
    } vec_t;

    initial begin
        vec_t        vecs[6];
        logic [15:0] cap, cap2, prev;
        logic [15:0] txw[3];
        logic [15:0] rxw[3];
        int          w, r0, t0, f0, nw, pbits;
        bit          partial, cpol, cpha, mol;

        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0065, 16'h0059, 16'h0065, 16'h0059};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h00A3, 16'h003C, 16'h00A3, 16'h003C};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h00C5, 16'h009A, 16'h00C5, 16'h009A};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h003E, 16'h0071, 16'h003E, 16'h0071};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'hBEEF, 16'h1234, 16'hBEEF, 16'h1234};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h8001, 16'hF00D, 16'h8001, 16'hF00D};

        rst_n = 1'b0; m_ss = 1'b1; m_sck = 1'b1; m_mosi = 1'b0;
        p_cpol = 1'b1; p_cpha = 1'b1; p_mol = 1'b1; txr = '0; sel = 1'b0;
        last_rx[0] = '0;
        last_rx[1] = '0;
        tick(3);
        #1;
        chk("reset rxr8", {24'h0, rxr8}, 32'h0);
        chk("reset rxr16", {16'h0, rxr16}, 32'h0);
        chk("reset oe/miso", {28'h0, oe8, miso8, oe16, miso16}, 32'h0);
        chk("reset pulses", {26'h0, rdone8, tdone8, fe8, rdone16, tdone16, fe16}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(6);

        // Single-word frames from the table
        for (int v = 0; v < 6; v++) begin
            sel = vecs[v].wide;
            w   = sel ? 16 : 8;
            txr = vecs[v].txr;
            r0 = cur_rd(); t0 = cur_td(); f0 = cur_fe();
            frame_begin(vecs[v].cpol, vecs[v].cpha, vecs[v].mol);
            chk($sformatf("vec%0d oe during frame", v), {31'h0, cur_oe()}, 32'h1);
            spi_bits(w, w, vecs[v].cpha, vecs[v].mol, vecs[v].mosi, cap);
            frame_end();
            chk($sformatf("vec%0d rxr", v), {16'h0, cur_rxr()}, {16'h0, vecs[v].exp_rx});
            chk($sformatf("vec%0d master capture", v), {16'h0, cap}, {16'h0, vecs[v].exp_cap});
            chk($sformatf("vec%0d rdone count", v), cur_rd() - r0, 32'd1);
            chk($sformatf("vec%0d tdone count", v), cur_td() - t0, 32'd1);
            chk($sformatf("vec%0d frame_err count", v), cur_fe() - f0, 32'd0);
            chk($sformatf("vec%0d oe/miso idle", v), {30'h0, cur_oe(), cur_miso()}, 32'h0);
            last_rx[sel] = vecs[v].exp_rx;
        end

        // Two words per frame, txr changed mid-word before the second load
        sel = 1'b0;
        for (int m = 0; m < 2; m++) begin
            cpol = (m == 1);
            cpha = (m == 0);
            mol  = (m == 0);
            q_clear();
            t0 = cur_td();
            txr = 16'h0059;
            frame_begin(cpol, cpha, mol);
            txr = 16'h000C;
            spi_bits(8, 8, cpha, mol, 16'h0012, cap);
            spi_bits(8, 8, cpha, mol, 16'h0034, cap2);
            frame_end();
            chk($sformatf("b2b%0d rdone count", m), q_size(), 32'd2);
            chk($sformatf("b2b%0d rxr word1", m), {16'h0, q_pop()}, 32'h12);
            chk($sformatf("b2b%0d rxr word2", m), {16'h0, q_pop()}, 32'h34);
            chk($sformatf("b2b%0d tx word1", m), {16'h0, cap}, 32'h59);
            chk($sformatf("b2b%0d tx word2", m), {16'h0, cap2}, 32'h0C);
            chk($sformatf("b2b%0d tdone count", m), cur_td() - t0, 32'd2);
            last_rx[0] = 16'h0034;
        end

        // Aborted frames: 3 bits (mode 3) and 7 bits (mode 0)
        for (int m = 0; m < 2; m++) begin
            pbits = (m == 0) ? 3 : 7;
            cpol = (m == 0);
            cpha = (m == 0);
            prev = last_rx[0];
            r0 = cur_rd(); f0 = cur_fe();
            frame_begin(cpol, cpha, 1'b1);
            spi_bits(8, pbits, cpha, 1'b1, 16'h00A5, cap);
            frame_end();
            chk($sformatf("abort%0d frame_err", m), cur_fe() - f0, 32'd1);
            chk($sformatf("abort%0d no rdone", m), cur_rd() - r0, 32'd0);
            chk($sformatf("abort%0d rxr held", m), {16'h0, cur_rxr()}, {16'h0, prev});
        end
        frame_begin(1'b1, 1'b1, 1'b1);
        spi_bits(8, 8, 1'b1, 1'b1, 16'h00FF, cap);
        frame_end();
        chk("after abort rxr", {16'h0, cur_rxr()}, 32'hFF);
        last_rx[0] = 16'h00FF;

        // Reset mid-frame, ss held low across release
        sel = 1'b0;
        txr = 16'h00E7;
        q_clear();
        r0 = rd8 + rd16; t0 = td8 + td16; f0 = fe8_cnt + fe16_cnt;
        frame_begin(1'b1, 1'b1, 1'b1);
        spi_bits(8, 5, 1'b1, 1'b1, 16'h005A, cap);
        rst_n = 1'b0;
        #1;
        chk("mid-reset outputs", {22'h0, oe8, miso8, rxr8}, 32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(4);
        spi_bits(8, 8, 1'b1, 1'b1, 16'h00C3, cap);
        tick(HALF);
        chk("no frame after release oe", {31'h0, oe8}, 32'h0);
        chk("no frame after release rxr", {24'h0, rxr8}, 32'h0);
        chk("rxr16 cleared by reset", {16'h0, rxr16}, 32'h0);
        chk("no pulses around reset", (rd8 + rd16) + (td8 + td16) + (fe8_cnt + fe16_cnt),
            r0 + t0 + f0);
        frame_end();
        last_rx[0] = '0;
        last_rx[1] = '0;
        frame_begin(1'b1, 1'b1, 1'b1);
        spi_bits(8, 8, 1'b1, 1'b1, 16'h0096, cap);
        frame_end();
        chk("fresh frame rxr", {24'h0, rxr8}, 32'h96);
        chk("fresh frame capture", {16'h0, cap}, 32'hE7);
        last_rx[0] = 16'h0096;

        // Random frames vs word-level model; mode pins scrambled mid-frame
        for (int it = 0; it < 24; it++) begin
            sel = 1'($urandom_range(0, 1));
            w   = sel ? 16 : 8;
            cpol = 1'($urandom); cpha = 1'($urandom); mol = 1'($urandom);
            nw = $urandom_range(1, 3);
            partial = ($urandom_range(0, 3) == 0);
            pbits = $urandom_range(1, w - 1);
            for (int k = 0; k < 3; k++) begin
                txw[k] = 16'($urandom);
                rxw[k] = 16'($urandom);
                if (w == 8) begin
                    txw[k][15:8] = 8'h00;
                    rxw[k][15:8] = 8'h00;
                end
            end
            q_clear();
            t0 = cur_td(); f0 = cur_fe();
            txr = txw[0];
            frame_begin(cpol, cpha, mol);
            p_cpol = 1'($urandom); p_cpha = 1'($urandom); p_mol = 1'($urandom);
            txr = txw[1];
            for (int k = 0; k < nw; k++) begin
                spi_bits(w, w, cpha, mol, rxw[k], cap);
                chk($sformatf("rnd%0d tx word%0d", it, k), {16'h0, cap}, {16'h0, txw[k]});
                if (k + 2 < 3) txr = txw[k + 2];
            end
            if (partial) spi_bits(w, pbits, cpha, mol, 16'($urandom), cap2);
            frame_end();
            last_rx[sel] = rxw[nw - 1];
            chk($sformatf("rnd%0d rdone count", it), q_size(), nw);
            for (int k = 0; k < nw; k++)
                chk($sformatf("rnd%0d rx word%0d", it, k), {16'h0, q_pop()}, {16'h0, rxw[k]});
            chk($sformatf("rnd%0d rxr", it), {16'h0, cur_rxr()}, {16'h0, last_rx[sel]});
            chk($sformatf("rnd%0d tdone count", it), cur_td() - t0, nw);
            chk($sformatf("rnd%0d frame_err", it), cur_fe() - f0, {31'h0, partial});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
